// File: rtl/mem_arb2_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb2_if
// Purpose  : Two-requester access bus plus single-port memory bus for mem_arb2.
// Revision : 1.0
// ============================================================================
interface mem_arb2_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [7:0]        conflicts;

  // Arbiter side
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_ack,
    output gnt0, gnt1, done0, done1, err, rdata, mem_cs, mem_we, mem_addr, mem_wdata,
    output conflicts
  );

  // Requesters and memory side
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_ack,
    input  gnt0, gnt1, done0, done1, err, rdata, mem_cs, mem_we, mem_addr, mem_wdata,
    input  conflicts
  );
endinterface
`default_nettype wire

// File: rtl/mem_arb2.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb2
// Purpose  : Round-robin two-requester memory arbiter with ack timeout.
// Revision : 1.0
// ============================================================================
module mem_arb2 #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int TMO    = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_arb2_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] c_TMO = 8'(TMO);

  state_t            r_state,     w_state_nxt;
  logic              r_last,      w_last_nxt;
  logic              r_win,       w_win_nxt;
  logic              r_cmd_we,    w_cmd_we_nxt;
  logic [ADDR_W-1:0] r_cmd_addr,  w_cmd_addr_nxt;
  logic [DATA_W-1:0] r_cmd_wdata, w_cmd_wdata_nxt;
  logic [7:0]        r_cnt,       w_cnt_nxt;
  logic [DATA_W-1:0] r_rdata,     w_rdata_nxt;
  logic [7:0]        r_conflicts, w_conflicts_nxt;
  logic              r_gnt0,      w_gnt0_nxt;
  logic              r_gnt1,      w_gnt1_nxt;
  logic              r_done0,     w_done0_nxt;
  logic              r_done1,     w_done1_nxt;
  logic              r_err,       w_err_nxt;
  logic              r_mem_cs,    w_mem_cs_nxt;
  logic              r_mem_we,    w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;

  logic              w_pick;
  logic              w_both;
  logic [7:0]        w_cnt_inc;
  logic              w_pick_we;
  logic [ADDR_W-1:0] w_pick_addr;
  logic [DATA_W-1:0] w_pick_wdata;

  // On a tie the requester that did not win last time goes next
  assign w_both       = bus.req0 & bus.req1;
  assign w_pick       = w_both ? ~r_last : bus.req1;
  assign w_pick_we    = w_pick ? bus.we1    : bus.we0;
  assign w_pick_addr  = w_pick ? bus.addr1  : bus.addr0;
  assign w_pick_wdata = w_pick ? bus.wdata1 : bus.wdata0;
  assign w_cnt_inc    = r_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_win       <= 1'b0;
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_cnt       <= 8'd0;
      r_rdata     <= '0;
      r_conflicts <= 8'd0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_err       <= 1'b0;
      r_mem_cs    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_win       <= w_win_nxt;
      r_cmd_we    <= w_cmd_we_nxt;
      r_cmd_addr  <= w_cmd_addr_nxt;
      r_cmd_wdata <= w_cmd_wdata_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rdata     <= w_rdata_nxt;
      r_conflicts <= w_conflicts_nxt;
      r_gnt0      <= w_gnt0_nxt;
      r_gnt1      <= w_gnt1_nxt;
      r_done0     <= w_done0_nxt;
      r_done1     <= w_done1_nxt;
      r_err       <= w_err_nxt;
      r_mem_cs    <= w_mem_cs_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_win_nxt       = r_win;
    w_cmd_we_nxt    = r_cmd_we;
    w_cmd_addr_nxt  = r_cmd_addr;
    w_cmd_wdata_nxt = r_cmd_wdata;
    w_cnt_nxt       = r_cnt;
    w_rdata_nxt     = r_rdata;
    w_conflicts_nxt = r_conflicts;
    w_gnt0_nxt      = 1'b0;
    w_gnt1_nxt      = 1'b0;
    w_done0_nxt     = 1'b0;
    w_done1_nxt     = 1'b0;
    w_err_nxt       = 1'b0;
    w_mem_cs_nxt    = r_mem_cs;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;

    case (r_state)
      S_IDLE: begin
        if (bus.req0 | bus.req1) begin
          w_state_nxt     = S_ACC;
          w_last_nxt      = w_pick;
          w_win_nxt       = w_pick;
          w_cmd_we_nxt    = w_pick_we;
          w_cmd_addr_nxt  = w_pick_addr;
          w_cmd_wdata_nxt = w_pick_wdata;
          w_cnt_nxt       = 8'd0;
          w_gnt0_nxt      = ~w_pick;
          w_gnt1_nxt      = w_pick;
          w_mem_cs_nxt    = 1'b1;
          w_mem_we_nxt    = w_pick_we;
          w_mem_addr_nxt  = w_pick_addr;
          w_mem_wdata_nxt = w_pick_wdata;
          if (w_both && (r_conflicts != 8'hFF)) begin
            w_conflicts_nxt = r_conflicts + 8'd1;
          end
        end
      end

      S_ACC: begin
        // r_cnt == 0 marks the grant cycle, where ack is not yet meaningful
        if (bus.mem_ack && (r_cnt != 8'd0)) begin
          w_state_nxt     = S_DONE;
          w_done0_nxt     = ~r_win;
          w_done1_nxt     = r_win;
          w_mem_cs_nxt    = 1'b0;
          w_mem_we_nxt    = 1'b0;
          w_mem_addr_nxt  = '0;
          w_mem_wdata_nxt = '0;
          if (!r_cmd_we) begin
            w_rdata_nxt = bus.mem_rdata;
          end
        end else if (w_cnt_inc == c_TMO) begin
          w_state_nxt     = S_DONE;
          w_done0_nxt     = ~r_win;
          w_done1_nxt     = r_win;
          w_err_nxt       = 1'b1;
          w_mem_cs_nxt    = 1'b0;
          w_mem_we_nxt    = 1'b0;
          w_mem_addr_nxt  = '0;
          w_mem_wdata_nxt = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt     = S_IDLE;
        w_mem_cs_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;
      end
    endcase
  end

  assign bus.gnt0      = r_gnt0;
  assign bus.gnt1      = r_gnt1;
  assign bus.done0     = r_done0;
  assign bus.done1     = r_done1;
  assign bus.err       = r_err;
  assign bus.rdata     = r_rdata;
  assign bus.mem_cs    = r_mem_cs;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.conflicts = r_conflicts;

endmodule
`default_nettype wire
